// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, FSM state types and helpers for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  // 32 shift/subtract iterations plus one sign-fix cycle.
  localparam int MDU_DIV_CYCLES = 33;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} mdu_state_e;
  typedef enum logic [1:0] {DC_IDLE, DC_ITER, DC_FIX} div_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Radix-2 restoring divider: 32 iterations on magnitudes, then one sign-fix cycle.
module mdu_div_core
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  div_state_e  state_reg, state_next;
  logic [4:0]  iter_reg;
  logic [31:0] rem_reg, quo_reg, dsr_reg;
  logic        q_neg_reg, r_neg_reg;
  logic [32:0] shifted, diff;

  always_comb begin
    shifted = {rem_reg, quo_reg[31]};
    diff    = shifted - {1'b0, dsr_reg};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DC_IDLE: if (go) state_next = DC_ITER;
      DC_ITER: if (iter_reg == 5'd31) state_next = DC_FIX;
      DC_FIX:  state_next = DC_IDLE;
      default: state_next = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DC_IDLE;
      iter_reg  <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DC_IDLE && go) begin
        iter_reg  <= '0;
        rem_reg   <= '0;
        quo_reg   <= mag32(dividend, sign);
        dsr_reg   <= mag32(divisor, sign);
        q_neg_reg <= sign && (dividend[31] ^ divisor[31]);
        r_neg_reg <= sign && dividend[31];
      end else if (state_reg == DC_ITER) begin
        iter_reg <= iter_reg + 5'd1;
        // Restore by keeping the shifted value when the trial subtract borrows.
        rem_reg  <= diff[32] ? shifted[31:0] : diff[31:0];
        quo_reg  <= {quo_reg[30:0], ~diff[32]};
      end
    end
  end

  assign done = (state_reg == DC_FIX);
  assign quot = q_neg_reg ? (32'd0 - quo_reg) : quo_reg;
  assign rem  = r_neg_reg ? (32'd0 - rem_reg) : rem_reg;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit; MDU_MADD_EN adds multiply-accumulate ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  mdu_state_e  state_reg, state_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] hi_reg, lo_reg, a_reg, b_reg;
  logic        sign_reg, dbz_reg;
  logic        accept, is_mul, is_div, op_sign, mul_commit, div_commit;
  logic [63:0] a_ext, b_ext, product, mul_result;
  logic        div_done;
  logic [31:0] div_quot, div_rem;
`ifdef MDU_MADD_EN
  logic        op_acc, op_sub, acc_en_reg, sub_reg;
  logic [63:0] acc_reg;
`endif

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    op_sign = 1'b0;
`ifdef MDU_MADD_EN
    op_acc  = 1'b0;
    op_sub  = 1'b0;
`endif
    case (MDUOp)
      MDU_MULT:  begin is_mul = 1'b1; op_sign = 1'b1; end
      MDU_MULTU: is_mul = 1'b1;
      MDU_DIV:   begin is_div = 1'b1; op_sign = 1'b1; end
      MDU_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin is_mul = 1'b1; op_sign = 1'b1; op_acc = 1'b1; end
      MDU_MADDU: begin is_mul = 1'b1; op_acc = 1'b1; end
      MDU_MSUB:  begin is_mul = 1'b1; op_sign = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      MDU_MSUBU: begin is_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept = Start && (state_reg == ST_IDLE);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (accept && is_mul)      state_next = ST_MUL;
        else if (accept && is_div) state_next = ST_DIV;
      end
      ST_MUL: begin
        if (count_reg == 32'(MULT_CYCLES - 1)) begin
          state_next = ST_IDLE;
          count_next = '0;
          mul_commit = 1'b1;
        end else begin
          count_next = count_reg + 32'd1;
        end
      end
      ST_DIV: begin
        if (count_reg == 32'(MDU_DIV_CYCLES - 2)) begin
          state_next = ST_FIX;
          count_next = '0;
        end else begin
          count_next = count_reg + 32'd1;
        end
      end
      ST_FIX: begin
        state_next = ST_IDLE;
        div_commit = div_done;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sign- or zero-extend to 64 bits so one multiplier serves both signednesses.
  always_comb begin
    a_ext   = sign_reg ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
    b_ext   = sign_reg ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
    product = a_ext * b_ext;
`ifdef MDU_MADD_EN
    if (acc_en_reg) mul_result = sub_reg ? (acc_reg - product) : (acc_reg + product);
    else            mul_result = product;
`else
    mul_result = product;
`endif
  end

  mdu_div_core u_div_core (
    .clk      (clk),
    .reset    (reset),
    .go       (accept && is_div),
    .sign     (op_sign),
    .dividend (A),
    .divisor  (B),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sign_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
`ifdef MDU_MADD_EN
      acc_en_reg <= 1'b0;
      sub_reg    <= 1'b0;
      acc_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        a_reg    <= A;
        b_reg    <= B;
        sign_reg <= op_sign;
        dbz_reg  <= (B == 32'd0);
`ifdef MDU_MADD_EN
        acc_en_reg <= op_acc;
        sub_reg    <= op_sub;
        acc_reg    <= {hi_reg, lo_reg};
`endif
        if (MDUOp == MDU_MTHI) hi_reg <= A;
        if (MDUOp == MDU_MTLO) lo_reg <= A;
      end
      if (mul_commit) {hi_reg, lo_reg} <= mul_result;
      if (div_commit && !dbz_reg) begin
        hi_reg <= div_rem;
        lo_reg <= div_quot;
      end
    end
  end

  assign Busy = (state_reg != ST_IDLE);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench with a cycle-level arithmetic model of HI/LO/Busy for mult_div_unit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDUOp = '0;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  mult_div_unit #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Model: results from plain arithmetic, held until latency expires.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_left = 0;
  bit          m_commit = 1'b0;

  function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  always @(posedge clk) begin
    int q, r;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_commit) {m_hi, m_lo} = m_res;
    end else if (Start) begin
      case (MDUOp)
        MDU_MTHI:  m_hi = A;
        MDU_MTLO:  m_lo = A;
        MDU_MULT:  begin m_res = smul(A, B); m_commit = 1'b1; m_left = MC; end
        MDU_MULTU: begin m_res = umul(A, B); m_commit = 1'b1; m_left = MC; end
`ifdef MDU_MADD_EN
        MDU_MADD:  begin m_res = {m_hi, m_lo} + smul(A, B); m_commit = 1'b1; m_left = MC; end
        MDU_MADDU: begin m_res = {m_hi, m_lo} + umul(A, B); m_commit = 1'b1; m_left = MC; end
        MDU_MSUB:  begin m_res = {m_hi, m_lo} - smul(A, B); m_commit = 1'b1; m_left = MC; end
        MDU_MSUBU: begin m_res = {m_hi, m_lo} - umul(A, B); m_commit = 1'b1; m_left = MC; end
`endif
        MDU_DIV: begin
          m_left = 33;
          m_commit = (B != 0);
          if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) m_res = {32'd0, 32'h8000_0000};
          else if (B != 0) begin
            q = $signed(A) / $signed(B);
            r = $signed(A) % $signed(B);
            m_res = {32'(r), 32'(q)};
          end
        end
        MDU_DIVU: begin
          m_left = 33;
          m_commit = (B != 0);
          if (B != 0) m_res = {A % B, A / B};
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, Busy}, {31'd0, m_left != 0});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  task automatic wait_idle(inout int cycles);
    while (Busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 200) check("busy_bound", 32'(cycles), 32'd0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    int n;
    @(negedge clk);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    wait_idle(n);
    cycles = n;
    $display("op=%0d A=%h B=%h busy_cycles=%0d HI=%h LO=%h", op, a, b, n, HI, LO);
  endtask

  initial begin
    int n;
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    do_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, n);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check("div_cycles", 32'(n), 32'd33);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    do_op(MDU_DIVU, 32'd100, 32'd7, n);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    do_op(MDU_MTHI, 32'h1234, 32'd0, n);
    check("mthi_cycles", 32'(n), 32'd0);
    do_op(MDU_DIV, 32'd5, 32'd0, n);
    check("dbz_cycles", 32'(n), 32'd33);
    check("dbz_hi", HI, 32'h1234);
    check("dbz_lo", LO, 32'd14);
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);
    do_op(MDU_DIVU, 32'hFFFF_FFFF, 32'd16, n);
    check("divu_big_lo", LO, 32'h0FFF_FFFF);
    check("divu_big_hi", HI, 32'd15);
    do_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, n);
    check("div_negdiv_lo", LO, 32'hFFFF_FFFD);
    check("div_negdiv_hi", HI, 32'd1);

    // mtlo presented while a mult is busy must be dropped.
    @(negedge clk);
    Start = 1'b1; MDUOp = MDU_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    MDUOp = MDU_MTLO; A = 32'hAA;
    n = (Busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    Start = 1'b0;
    wait_idle(n);
    $display("op=mult+mtlo busy_cycles=%0d HI=%h LO=%h", n, HI, LO);
    check("ignore_cycles", 32'(n), 32'd5);
    check("ignore_lo", LO, 32'd12);
    check("ignore_hi", HI, 32'd0);

    do_op(4'd0, 32'h55, 32'h66, n);
    check("unknown0_cycles", 32'(n), 32'd0);
    check("unknown0_lo", LO, 32'd12);
    do_op(4'd15, 32'h55, 32'h66, n);
    check("unknown15_cycles", 32'(n), 32'd0);

    // Reset at E0+10 of a divide.
    @(negedge clk);
    Start = 1'b1; MDUOp = MDU_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("op=div+reset Busy=%b HI=%h LO=%h", Busy, HI, LO);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    do_op(MDU_MULTU, 32'd3, 32'd4, n);
    check("post_reset_lo", LO, 32'd12);

    // Reset wins over a simultaneous Start.
    @(negedge clk);
    reset = 1'b1; Start = 1'b1; MDUOp = MDU_MULT; A = 32'd5; B = 32'd5;
    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    @(negedge clk);
    $display("op=reset+start Busy=%b LO=%h", Busy, LO);
    check("rst_start_busy", {31'd0, Busy}, 32'd0);
    check("rst_start_lo", LO, 32'd0);

    do_op(MDU_MTHI, 32'd0, 32'd0, n);
    do_op(MDU_MTLO, 32'd5, 32'd0, n);
    do_op(MDU_MADD, 32'd3, 32'd4, n);
`ifdef MDU_MADD_EN
    check("madd_cycles", 32'(n), 32'd5);
    check("madd_lo", LO, 32'd17);
    check("madd_hi", HI, 32'd0);
    do_op(MDU_MSUB, 32'd3, 32'd6, n);
    check("msub_lo", LO, 32'hFFFF_FFFF);
    check("msub_hi", HI, 32'hFFFF_FFFF);
`else
    check("madd_cycles", 32'(n), 32'd0);
    check("madd_lo", LO, 32'd5);
    check("madd_hi", HI, 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
